// File: rtl/dmem_write_buffer.sv
// Data-memory responder: posted-store FIFO in front of a word-addressed array,
// with store-to-load forwarding and a debug/loader write port that preempts draining.
module dmem_write_buffer #(
   parameter int AW       = 6,
   parameter int WB_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        memwrite,
   input  logic [31:0]                 aluout,
   input  logic [31:0]                 writedata,
   output logic [31:0]                 readdata,
   output logic                        stall,
   output logic                        misalign,
   input  logic                        dbg_we,
   input  logic [AW-1:0]               dbg_addr,
   input  logic [31:0]                 dbg_wdata,
   output logic [31:0]                 dbg_rdata,
   output logic [$clog2(WB_DEPTH):0]   wb_count
);

   localparam int PW = $clog2(WB_DEPTH);
   localparam int NW = 2**AW;

   logic [31:0]         mem_reg     [NW];
   logic [AW-1:0]       wb_addr_reg [WB_DEPTH];
   logic [31:0]         wb_data_reg [WB_DEPTH];
   logic [WB_DEPTH-1:0] wb_valid_reg;
   logic [WB_DEPTH-1:0] wb_valid_next;
   logic [PW-1:0]       head_reg;
   logic [PW-1:0]       head_next;
   logic [PW-1:0]       tail_reg;
   logic [PW-1:0]       tail_next;
   logic [PW:0]         count_reg;
   logic [PW:0]         count_next;
   logic                misalign_reg;

   logic [AW-1:0]       widx;
   logic                aligned;
   logic                full;
   logic                enq;
   logic                pop;
   logic                drain_wr;
   logic                unused_aluout_hi;

   logic [PW-1:0]       age_slot [WB_DEPTH];
   logic [WB_DEPTH-1:0] age_hit;
   logic                fwd_hit;
   logic [31:0]         fwd_data;

   assign widx             = aluout[AW+1:2];
   assign unused_aluout_hi = ^aluout[31:AW+2];
   assign aligned          = (aluout[1:0] == 2'b00);
   assign full             = (count_reg == (PW+1)'(WB_DEPTH));
   assign enq              = memwrite & aligned & ~full;
   assign pop              = (count_reg != '0) & ~dbg_we;
   // An entry invalidated by a debug write is popped without touching the array.
   assign drain_wr         = pop & wb_valid_reg[head_reg];

   assign stall    = memwrite & full & aligned;
   assign misalign = misalign_reg;
   assign wb_count = count_reg;

   assign head_next  = pop ? head_reg + PW'(1) : head_reg;
   assign tail_next  = enq ? tail_reg + PW'(1) : tail_reg;
   assign count_next = count_reg + {{PW{1'b0}}, enq} - {{PW{1'b0}}, pop};

   // The slot being enqueued is never the one popped: that would need count 0 and full at once.
   genvar gi;
   generate
      for (gi = 0; gi < WB_DEPTH; gi++) begin : g_slot
         logic set_v;
         logic clr_v;
         assign set_v = enq & (tail_reg == PW'(gi));
         assign clr_v = (pop & (head_reg == PW'(gi)))
                      | (dbg_we & (wb_addr_reg[gi] == dbg_addr));
         assign wb_valid_next[gi] = set_v ? 1'b1 : (clr_v ? 1'b0 : wb_valid_reg[gi]);
      end
   endgenerate

   // Age 0 is the oldest entry; later ages override earlier matches.
   generate
      for (gi = 0; gi < WB_DEPTH; gi++) begin : g_age
         assign age_slot[gi] = head_reg + PW'(gi);
         assign age_hit[gi]  = wb_valid_reg[age_slot[gi]] & (wb_addr_reg[age_slot[gi]] == widx);
      end
   endgenerate

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
         if (age_hit[k]) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data_reg[age_slot[k]];
         end
      end
   end

   assign readdata  = fwd_hit ? fwd_data : mem_reg[widx];
   assign dbg_rdata = mem_reg[dbg_addr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         wb_valid_reg <= '0;
         misalign_reg <= 1'b0;
      end else begin
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         count_reg    <= count_next;
         wb_valid_reg <= wb_valid_next;
         misalign_reg <= memwrite & ~aligned;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         wb_addr_reg[tail_reg] <= widx;
         wb_data_reg[tail_reg] <= writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (dbg_we) begin
         mem_reg[dbg_addr] <= dbg_wdata;
      end else if (drain_wr) begin
         mem_reg[wb_addr_reg[head_reg]] <= wb_data_reg[head_reg];
      end
   end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Randomized and directed bench for dmem_write_buffer against a queue-based
// model of the store buffer and a plain array model of memory.
module tb_dmem_write_buffer;

   localparam int AW    = 6;
   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        stall;
   logic        misalign;
   logic        dbg_we;
   logic [5:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic [31:0] dbg_rdata;
   logic [2:0]  wb_count;

   dmem_write_buffer #(.AW(AW), .WB_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
      .writedata(writedata), .readdata(readdata), .stall(stall),
      .misalign(misalign), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .wb_count(wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
      bit          v;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mm    [64];
   bit          known [64];
   logic [31:0] pre   [64];

   int errors = 0;
   int checks = 0;

   bit          exp_stall;
   logic [31:0] obs_rd;
   logic [31:0] obs_dbg;
   logic        obs_stall;
   logic [2:0]  obs_cnt;
   logic        obs_mis;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: check combinational outputs, step the model, check registered outputs.
   task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                      input logic dwe, input logic [5:0] da, input logic [31:0] dwd);
      logic [5:0]  w;
      logic [31:0] ev;
      bit          hit;
      bit          mis;
      int          sz0;
      ent_t        e;
      memwrite  = mw;
      aluout    = a;
      writedata = wd;
      dbg_we    = dwe;
      dbg_addr  = da;
      dbg_wdata = dwd;
      #1;
      w   = a[7:2];
      hit = 0;
      ev  = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!hit && q[i].v && q[i].a == w) begin
            hit = 1;
            ev  = q[i].d;
         end
      end
      obs_rd    = readdata;
      obs_dbg   = dbg_rdata;
      obs_stall = stall;
      if (hit) check("readdata_fwd", readdata, ev);
      else if (known[w]) check("readdata_arr", readdata, mm[w]);
      if (known[da]) check("dbg_rdata", dbg_rdata, mm[da]);
      exp_stall = mw && (a[1:0] == 2'b00) && (q.size() == DEPTH);
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      if (mw || dwe)
         $display("t=%0t mw=%0b a=%08h wd=%08h dwe=%0b da=%0d dwd=%08h rd=%08h stall=%0b cnt=%0d",
                  $time, mw, a, wd, dwe, da, dwd, readdata, stall, q.size());
      @(posedge clk);
      mis = mw && (a[1:0] != 2'b00);
      sz0 = q.size();
      if (dwe) begin
         mm[da]    = dwd;
         known[da] = 1;
         foreach (q[i]) if (q[i].a == da) q[i].v = 0;
      end else if (sz0 > 0) begin
         e = q.pop_front();
         if (e.v) begin
            mm[e.a]    = e.d;
            known[e.a] = 1;
         end
      end
      if (mw && a[1:0] == 2'b00 && sz0 < DEPTH) begin
         e.a = w;
         e.d = wd;
         e.v = 1;
         q.push_back(e);
      end
      #1;
      obs_cnt = wb_count;
      obs_mis = misalign;
      check("wb_count", {29'b0, wb_count}, q.size());
      check("misalign", {31'b0, misalign}, {31'b0, mis});
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0);
   endtask

   task automatic rb(input logic [5:0] w);
      cyc(1'b0, {24'h0, w, 2'b00}, 32'h0, 1'b0, w, 32'h0);
   endtask

   initial begin
      int          sp;
      int          acc_cyc;
      logic [31:0] r;
      logic [5:0]  w;
      logic [1:0]  off;

      foreach (known[i]) known[i] = 0;
      reset = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0;
      dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      @(posedge clk); #1;
      check("rst_count", {29'b0, wb_count}, 32'd0);
      check("rst_misalign", {31'b0, misalign}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Preload every array word through the debug port.
      for (int i = 0; i < 64; i++) begin
         r      = $urandom;
         pre[i] = r;
         cyc(1'b0, 32'h0, 32'h0, 1'b1, 6'(i), r);
      end

      // Reset with three pending stores: they must be lost.
      cyc(1'b1, 32'h50, 32'h11110000, 1'b1, 6'd50, 32'h0BAD0050);
      cyc(1'b1, 32'h54, 32'h11110001, 1'b1, 6'd50, 32'h0BAD0051);
      cyc(1'b1, 32'h58, 32'h11110002, 1'b1, 6'd50, 32'h0BAD0052);
      check("pend3", {29'b0, obs_cnt}, 32'd3);
      dbg_we = 1'b0; memwrite = 1'b1; aluout = 32'h5C;
      reset  = 1'b0;
      #1;
      q.delete();
      check("rst_mid_count", {29'b0, wb_count}, 32'd0);
      check("rst_mid_stall", {31'b0, stall}, 32'd0);
      check("rst_mid_misalign", {31'b0, misalign}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      rb(6'd20);
      check("rst_arr20", obs_dbg, pre[20]);
      rb(6'd22);
      check("rst_arr22", obs_dbg, pre[22]);

      // Store then load next cycle: forwarded; two edges later it is in the array.
      cyc(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0);
      cyc(1'b0, 32'h10, 32'h0, 1'b0, 6'd4, 32'h0);
      check("fwd_deadbeef", obs_rd, 32'hDEADBEEF);
      rb(6'd4);
      check("arr4_deadbeef", obs_dbg, 32'hDEADBEEF);

      // Debug port blocks draining for six cycles while five stores arrive.
      sp      = 0;
      acc_cyc = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc(sp < 5, 32'(sp * 4), 32'hA000 + 32'(sp), c <= 6, 6'd40, 32'h5A5A0000 + 32'(c));
         if (c == 4) check("fill_cnt4", {29'b0, obs_cnt}, 32'd4);
         if (c == 5) check("stall_5th", {31'b0, obs_stall}, 32'd1);
         if (sp < 5 && !exp_stall) begin
            if (sp == 4) acc_cyc = c;
            sp++;
         end
      end
      check("accept_cycle", 32'(acc_cyc), 32'd8);
      idle(4);
      for (int i = 0; i < 5; i++) begin
         rb(6'(i));
         check("order_arr", obs_dbg, 32'hA000 + 32'(i));
      end

      // Two stores to one word with drain blocked: newest forwards and lands last.
      cyc(1'b1, 32'h20, 32'h1111, 1'b1, 6'd41, 32'h1);
      cyc(1'b1, 32'h20, 32'h2222, 1'b1, 6'd41, 32'h2);
      cyc(1'b0, 32'h20, 32'h0, 1'b1, 6'd41, 32'h3);
      check("fwd_newest", obs_rd, 32'h2222);
      idle(3);
      rb(6'd8);
      check("arr8_newest", obs_dbg, 32'h2222);

      // Debug write to a word with a pending store makes the debug write last.
      cyc(1'b1, 32'hC, 32'h1234, 1'b1, 6'd42, 32'h7);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 6'd3, 32'hCAFE);
      cyc(1'b0, 32'hC, 32'h0, 1'b0, 6'd0, 32'h0);
      check("dbg_last_rd", obs_rd, 32'hCAFE);
      idle(2);
      rb(6'd3);
      check("dbg_last_arr", obs_dbg, 32'hCAFE);

      // Misaligned store is dropped with a one-cycle pulse.
      r = mm[4];
      cyc(1'b1, 32'h13, 32'h99999999, 1'b0, 6'd4, 32'h0);
      check("mis_pulse", {31'b0, obs_mis}, 32'd1);
      check("mis_stall", {31'b0, obs_stall}, 32'd0);
      check("mis_count", {29'b0, obs_cnt}, 32'd0);
      rb(6'd4);
      check("mis_pulse_end", {31'b0, obs_mis}, 32'd0);
      check("mis_arr4", obs_dbg, r);

      // Random mix over a small address window to provoke collisions and aliasing.
      for (int i = 0; i < 300; i++) begin
         w   = 6'($urandom_range(0, 7));
         off = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cyc($urandom_range(0, 1) == 1, {24'($urandom), w, off}, $urandom,
             $urandom_range(0, 3) == 0, 6'($urandom_range(0, 7)), $urandom);
      end
      idle(6);
      for (int i = 0; i < 8; i++) rb(6'(i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
